// File: rtl/packet_route_split_pkg.sv
// ---------------------------------------------------------------------------
// packet_route_split_pkg
// Shared NoC definitions: flit geometry, output port indices (as the route
// enum), the splitter FSM state type and a helper to pull the destination
// field out of a flit.
// ---------------------------------------------------------------------------
package packet_route_split_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned FLIT_W    = 11;
  localparam int unsigned DEST_W    = 4;
  localparam int unsigned TOKEN_W   = 3;
  localparam int unsigned PORT_W    = 3;
  localparam int unsigned CNT_W     = 16;

  // Flit layout: {dest[3:0], payload[6:0]}; dest = {x[1:0], y[1:0]}
  localparam int unsigned DEST_MSB  = 10;
  localparam int unsigned DEST_LSB  = 7;

  // Output port indices double as the route decode result
  typedef enum logic [PORT_W-1:0] {
    ROUTE_EAST  = 3'd0,
    ROUTE_WEST  = 3'd1,
    ROUTE_NORTH = 3'd2,
    ROUTE_SOUTH = 3'd3,
    ROUTE_CORE  = 3'd4
  } route_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic logic [DEST_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
    return flit[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/xy_route_decode.sv
// ---------------------------------------------------------------------------
// xy_route_decode
// Combinational XY route decode: X is resolved first, then Y, otherwise the
// flit is for the local core.
//   MY_ADDR : local node address {x[1:0], y[1:0]}
//   dest    : flit destination {x[1:0], y[1:0]}
//   port    : output port index (route_e encoding)
// ---------------------------------------------------------------------------
module xy_route_decode
  import packet_route_split_pkg::*;
#(
  parameter logic [3:0] MY_ADDR = 4'b0000
) (
  input  logic [DEST_W-1:0] dest,
  output logic [PORT_W-1:0] port
);

  // Priority decode, first matching rule wins
  always_comb begin
    port = ROUTE_CORE;
    if (dest[3:2] > MY_ADDR[3:2]) begin
      port = ROUTE_EAST;
    end else if (dest[3:2] < MY_ADDR[3:2]) begin
      port = ROUTE_WEST;
    end else if (dest[1:0] > MY_ADDR[1:0]) begin
      port = ROUTE_NORTH;
    end else if (dest[1:0] < MY_ADDR[1:0]) begin
      port = ROUTE_SOUTH;
    end else begin
      port = ROUTE_CORE;
    end
  end

endmodule

// File: rtl/packet_route_split.sv
// ---------------------------------------------------------------------------
// packet_route_split
// Accepts one flit, routes it XY to one of five ports and delivers it there
// as two independent handshakes: the flit itself on out_* and an arbiter
// token (SRC_ID) on ctl_*. The held slot frees the cycle both have gone,
// and a new flit may be accepted in that same cycle (bypass).
//   CLK, RESET             : clock, synchronous active-high reset
//   in_data/valid/ready    : flit input
//   out_data/valid/ready   : per-port flit output (0=E 1=W 2=N 3=S 4=core)
//   ctl_data/valid/ready   : per-port arbiter token output
//   pkt_count              : flits fully delivered (wraps)
// ---------------------------------------------------------------------------
module packet_route_split
  import packet_route_split_pkg::*;
#(
  parameter logic [3:0] MY_ADDR = 4'b0000,
  parameter logic [2:0] SRC_ID  = 3'b000
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic [FLIT_W-1:0]                     in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [NUM_PORTS-1:0][FLIT_W-1:0]      out_data,
  output logic [NUM_PORTS-1:0]                  out_valid,
  input  logic [NUM_PORTS-1:0]                  out_ready,
  output logic [NUM_PORTS-1:0][TOKEN_W-1:0]     ctl_data,
  output logic [NUM_PORTS-1:0]                  ctl_valid,
  input  logic [NUM_PORTS-1:0]                  ctl_ready,
  output logic [CNT_W-1:0]                      pkt_count
);

  state_e                              state_q, state_d;
  logic [FLIT_W-1:0]                   flit_q, flit_d;
  logic [PORT_W-1:0]                   port_q, port_d;
  logic                                data_sent_q, data_sent_d;
  logic                                ctl_sent_q, ctl_sent_d;
  logic [CNT_W-1:0]                    pkt_count_q, pkt_count_d;

  logic [PORT_W-1:0]                   route_s;
  logic                                hold_s;
  logic                                data_hs_s, ctl_hs_s;
  logic                                data_done_s, ctl_done_s;
  logic                                done_s, accept_s, in_ready_s;
  logic [NUM_PORTS-1:0]                out_valid_s, ctl_valid_s;
  logic [NUM_PORTS-1:0][FLIT_W-1:0]    out_data_s;
  logic [NUM_PORTS-1:0][TOKEN_W-1:0]   ctl_data_s;

  xy_route_decode #(.MY_ADDR(MY_ADDR)) u_route (
    .dest (flit_dest(in_data)),
    .port (route_s)
  );

  // Per-port outputs: only the routed port carries anything while holding
  always_comb begin
    hold_s      = (state_q == ST_HOLD);
    out_valid_s = '0;
    ctl_valid_s = '0;
    out_data_s  = '0;
    ctl_data_s  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (hold_s && (port_q == PORT_W'(p))) begin
        out_valid_s[p] = ~data_sent_q;
        ctl_valid_s[p] = ~ctl_sent_q;
        out_data_s[p]  = flit_q;
        ctl_data_s[p]  = SRC_ID;
      end else begin
        out_valid_s[p] = 1'b0;
        ctl_valid_s[p] = 1'b0;
        out_data_s[p]  = '0;
        ctl_data_s[p]  = '0;
      end
    end
    // Masking with the valids makes readys on other ports irrelevant
    data_hs_s   = |(out_valid_s & out_ready);
    ctl_hs_s    = |(ctl_valid_s & ctl_ready);
    data_done_s = data_sent_q | data_hs_s;
    ctl_done_s  = ctl_sent_q | ctl_hs_s;
    done_s      = hold_s & data_done_s & ctl_done_s;
    in_ready_s  = ~RESET & (~hold_s | done_s);
    accept_s    = in_valid & in_ready_s;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    flit_d      = flit_q;
    port_d      = port_q;
    data_sent_d = data_sent_q;
    ctl_sent_d  = ctl_sent_q;
    pkt_count_d = pkt_count_q + {15'd0, done_s};

    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (done_s && !accept_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (accept_s) begin
      flit_d      = in_data;
      port_d      = route_s;
      data_sent_d = 1'b0;
      ctl_sent_d  = 1'b0;
    end else if (done_s) begin
      data_sent_d = 1'b0;
      ctl_sent_d  = 1'b0;
    end else if (hold_s) begin
      data_sent_d = data_done_s;
      ctl_sent_d  = ctl_done_s;
    end else begin
      data_sent_d = data_sent_q;
      ctl_sent_d  = ctl_sent_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_EMPTY;
      flit_q      <= '0;
      port_q      <= '0;
      data_sent_q <= 1'b0;
      ctl_sent_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      flit_q      <= flit_d;
      port_q      <= port_d;
      data_sent_q <= data_sent_d;
      ctl_sent_q  <= ctl_sent_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign ctl_valid = ctl_valid_s;
  assign out_data  = out_data_s;
  assign ctl_data  = ctl_data_s;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_packet_route_split.sv
// ---------------------------------------------------------------------------
// tb_packet_route_split
// Scoreboard bench: the driver pushes the expected route/flit of every
// accepted flit into data and token queues; a negedge monitor compares the
// DUT's per-port outputs against the queue heads and tracks deliveries.
// ---------------------------------------------------------------------------
module tb_packet_route_split;

  localparam logic [3:0] MY  = 4'b0101;
  localparam logic [2:0] SRC = 3'b101;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [10:0]       in_data = 11'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0][10:0]  out_data;
  logic [4:0]        out_valid;
  logic [4:0]        out_ready = 5'd0;
  logic [4:0][2:0]   ctl_data;
  logic [4:0]        ctl_valid;
  logic [4:0]        ctl_ready = 5'd0;
  logic [15:0]       pkt_count;

  typedef struct { int port; logic [10:0] flit; } exp_t;
  exp_t data_q[$];
  exp_t ctl_q[$];
  int   nd = 0;
  int   nc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   rand_rdy = 1'b0;

  packet_route_split #(.MY_ADDR(MY), .SRC_ID(SRC)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ctl_data(ctl_data), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
    .pkt_count(pkt_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference XY routing straight from the rules
  function automatic int ref_port(input logic [3:0] d);
    int dx, dy, mx, my;
    dx = int'(d[3:2]); dy = int'(d[1:0]);
    mx = int'(MY[3:2]); my = int'(MY[1:0]);
    if (dx > mx) return 0;
    if (dx < mx) return 1;
    if (dy > my) return 2;
    if (dy < my) return 3;
    return 4;
  endfunction

  task automatic push(input logic [10:0] d);
    exp_t e;
    e.port = ref_port(d[10:7]);
    e.flit = d;
    data_q.push_back(e);
    ctl_q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer one flit until accepted (bounded); returns just after the accept edge
  task automatic send(input logic [10:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK); #2;
      if (in_ready) begin
        ok = 1'b1;
        push(d);
      end
      step();
    end
    in_valid = 1'b0;
    chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  // Back-to-back flits; every cycle must accept
  task automatic stream(input int n);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = 11'($urandom);
      @(negedge CLK); #2;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (in_ready) push(in_data);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Random ready pattern on all ports while enabled
  always @(posedge CLK) begin
    #1;
    if (rand_rdy) begin
      out_ready = 5'($urandom);
      ctl_ready = 5'($urandom);
    end
  end

  // Monitor: compare outputs against the queue heads, then retire handshakes
  always @(negedge CLK) begin : mon
    logic [4:0] eo, ec;
    eo = (data_q.size() != 0) ? 5'(1 << data_q[0].port) : 5'd0;
    ec = (ctl_q.size()  != 0) ? 5'(1 << ctl_q[0].port)  : 5'd0;
    chk("out_valid", {27'd0, out_valid}, {27'd0, eo});
    chk("ctl_valid", {27'd0, ctl_valid}, {27'd0, ec});
    if (data_q.size() != 0) chk("out_data", {21'd0, out_data[data_q[0].port]}, {21'd0, data_q[0].flit});
    if (ctl_q.size() != 0)  chk("ctl_data", {29'd0, ctl_data[ctl_q[0].port]}, {29'd0, SRC});
    chk("pkt_count", {16'd0, pkt_count}, {16'd0, 16'((nd < nc) ? nd : nc)});
    if (RESET) begin
      chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
      data_q.delete();
      ctl_q.delete();
      nd = 0;
      nc = 0;
    end else begin
      if (data_q.size() != 0 && out_valid[data_q[0].port] && out_ready[data_q[0].port]) begin
        void'(data_q.pop_front());
        nd++;
      end
      if (ctl_q.size() != 0 && ctl_valid[ctl_q[0].port] && ctl_ready[ctl_q[0].port]) begin
        void'(ctl_q.pop_front());
        nc++;
      end
    end
  end

  initial begin
    // Reset state
    RESET = 1'b1;
    step();
    step();
    @(negedge CLK); #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {27'd0, out_valid}, 32'd0);
    chk("rst_ctl_valid", {27'd0, ctl_valid}, 32'd0);
    chk("rst_out_data_zero", {31'd0, (out_data == '0)}, 32'd1);
    chk("rst_ctl_data_zero", {31'd0, (ctl_data == '0)}, 32'd1);
    chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    step();

    // Accept right after reset; flit 1001_0000001 at node 0101 goes east
    RESET = 1'b0;
    in_valid = 1'b1;
    in_data = 11'b1001_0000001;
    out_ready = 5'b11111;
    ctl_ready = 5'b11111;
    @(negedge CLK); #2;
    chk("first_accept_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) push(in_data);
    step();
    in_valid = 1'b0;
    @(negedge CLK); #2;
    chk("east_out_valid", {27'd0, out_valid}, 32'h01);
    chk("east_ctl_token", {29'd0, ctl_data[0]}, {29'd0, SRC});
    step();
    @(negedge CLK); #2;
    chk("east_pkt_count", {16'd0, pkt_count}, 32'd1);
    step();

    // South and core routes, only the selected valid rises
    out_ready = 5'd0;
    ctl_ready = 5'd0;
    send(11'b0100_0010101);
    @(negedge CLK); #2;
    chk("south_out_valid", {27'd0, out_valid}, 32'h08);
    chk("south_ctl_valid", {27'd0, ctl_valid}, 32'h08);
    step();
    out_ready = 5'b11111;
    ctl_ready = 5'b11111;
    step();
    out_ready = 5'd0;
    ctl_ready = 5'd0;
    send(11'b0101_1110000);
    @(negedge CLK); #2;
    chk("core_out_valid", {27'd0, out_valid}, 32'h10);
    chk("core_ctl_valid", {27'd0, ctl_valid}, 32'h10);
    step();
    out_ready = 5'b11111;
    ctl_ready = 5'b11111;
    step();
    @(negedge CLK); #2;
    chk("core_pkt_count", {16'd0, pkt_count}, 32'd3);
    step();

    // Split acceptance: token taken at once, data stalled for 3 cycles
    out_ready = 5'd0;
    ctl_ready = 5'b11111;
    send(11'b1001_1010101);
    @(negedge CLK); #2;
    chk("split_c1_ctl_valid", {27'd0, ctl_valid}, 32'h01);
    chk("split_c1_out_valid", {27'd0, out_valid}, 32'h01);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge CLK); #2;
      chk("split_ctl_dropped", {27'd0, ctl_valid}, 32'h00);
      chk("split_out_held", {27'd0, out_valid}, 32'h01);
      chk("split_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    step();
    out_ready = 5'b11111;
    @(negedge CLK); #2;
    chk("split_in_ready_bypass", {31'd0, in_ready}, 32'd1);
    step();
    @(negedge CLK); #2;
    chk("split_pkt_count", {16'd0, pkt_count}, 32'd4);
    step();

    // Streaming: 8 flits back to back
    do_reset();
    out_ready = 5'b11111;
    ctl_ready = 5'b11111;
    stream(8);
    step();
    @(negedge CLK); #2;
    chk("stream_pkt_count", {16'd0, pkt_count}, 32'd8);
    step();

    // Reset while holding discards the flit
    out_ready = 5'd0;
    ctl_ready = 5'd0;
    send(11'b0011_0001111);
    step();
    RESET = 1'b1;
    step();
    @(negedge CLK); #2;
    chk("rst_hold_out_valid", {27'd0, out_valid}, 32'd0);
    chk("rst_hold_ctl_valid", {27'd0, ctl_valid}, 32'd0);
    chk("rst_hold_pkt_count", {16'd0, pkt_count}, 32'd0);
    step();
    RESET = 1'b0;
    out_ready = 5'b11111;
    ctl_ready = 5'b11111;
    repeat (3) step();
    @(negedge CLK); #2;
    chk("rst_hold_never_sent", {16'd0, pkt_count}, 32'd0);
    step();

    // Random traffic with random readys on every port
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) step();
      send(11'($urandom));
    end
    rand_rdy = 1'b0;
    step();
    out_ready = 5'b11111;
    ctl_ready = 5'b11111;
    repeat (4) step();
    chk("random_drained", 32'(data_q.size() + ctl_q.size()), 32'd0);

    // Counter wrap
    do_reset();
    stream(65535);
    step();
    @(negedge CLK); #2;
    chk("wrap_ffff", {16'd0, pkt_count}, 32'h0000FFFF);
    step();
    stream(1);
    step();
    @(negedge CLK); #2;
    chk("wrap_zero", {16'd0, pkt_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
